// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative L1 cache: zero-wait hits, dirty-victim
// write-back and line allocate, plus wrapping hit/miss counters for debug.
module cache_control #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 hit,
  input  logic                 access1,
  input  logic                 access2,
  input  logic                 lru_out,
  input  logic                 dirty_out,
  output logic                 write_back,
  output logic                 write1,
  output logic                 write2,
  output logic                 load_dbit1,
  output logic                 load_dbit2,
  output logic                 load_lru,
  output logic                 set_dbit,
  output logic                 set_lbit,
  output logic                 set_vbit,
  output logic                 load_vbit1,
  output logic                 load_vbit2,
  output logic                 load_data1,
  output logic                 load_data2,
  output logic                 load_tag1,
  output logic                 load_tag2,
  output logic                 data_sel,
  output logic                 phys_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0] state, next_state;
  logic       req, hit_evt, miss_evt;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (hit_evt)  hit_count  <= hit_count + CNT_WIDTH'(1);
      if (miss_evt) miss_count <= miss_count + CNT_WIDTH'(1);
    end
  end

  // Strobes are forced low while reset is held so no array is touched then.
  always_comb begin
    next_state = state;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    write_back = 1'b0;
    write1     = 1'b0;
    write2     = 1'b0;
    load_dbit1 = 1'b0;
    load_dbit2 = 1'b0;
    load_lru   = 1'b0;
    set_dbit   = 1'b0;
    set_lbit   = 1'b0;
    set_vbit   = 1'b0;
    load_vbit1 = 1'b0;
    load_vbit2 = 1'b0;
    load_data1 = 1'b0;
    load_data2 = 1'b0;
    load_tag1  = 1'b0;
    load_tag2  = 1'b0;
    data_sel   = 1'b0;
    phys_sel   = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              mem_resp = 1'b1;
              load_lru = 1'b1;
              set_lbit = access1;
              hit_evt  = 1'b1;
              if (mem_write) begin
                write1     = access1;
                write2     = access2;
                load_dbit1 = access1;
                load_dbit2 = access2;
                set_dbit   = 1'b1;
              end
            end else begin
              miss_evt   = 1'b1;
              next_state = dirty_out ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          write_back = 1'b1;
          phys_sel   = lru_out;
          data_sel   = lru_out;
          if (pmem_resp) next_state = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_data1 = ~lru_out;
            load_tag1  = ~lru_out;
            load_vbit1 = ~lru_out;
            load_dbit1 = ~lru_out;
            load_data2 = lru_out;
            load_tag2  = lru_out;
            load_vbit2 = lru_out;
            load_dbit2 = lru_out;
            set_vbit   = 1'b1;
            set_dbit   = 1'b0;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: a tag-level 2-way cache model supplies datapath status
// and predicts every control strobe and counter value cycle by cycle.
module tb_cache_control;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n, mem_read, mem_write, pmem_resp;
  logic hit, access1, access2, lru_out, dirty_out;
  logic mem_resp, pmem_read, pmem_write, write_back, write1, write2;
  logic load_dbit1, load_dbit2, load_lru, set_dbit, set_lbit, set_vbit;
  logic load_vbit1, load_vbit2, load_data1, load_data2, load_tag1, load_tag2;
  logic data_sel, phys_sel;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit(hit), .access1(access1), .access2(access2),
    .lru_out(lru_out), .dirty_out(dirty_out), .write_back(write_back),
    .write1(write1), .write2(write2), .load_dbit1(load_dbit1),
    .load_dbit2(load_dbit2), .load_lru(load_lru), .set_dbit(set_dbit),
    .set_lbit(set_lbit), .set_vbit(set_vbit), .load_vbit1(load_vbit1),
    .load_vbit2(load_vbit2), .load_data1(load_data1), .load_data2(load_data2),
    .load_tag1(load_tag1), .load_tag2(load_tag2), .data_sel(data_sel),
    .phys_sel(phys_sel), .hit_count(hit_count), .miss_count(miss_count)
  );

  localparam logic [19:0] MR   = 20'd1 << 19;
  localparam logic [19:0] PR   = 20'd1 << 18;
  localparam logic [19:0] PW   = 20'd1 << 17;
  localparam logic [19:0] WB   = 20'd1 << 16;
  localparam logic [19:0] W1   = 20'd1 << 15;
  localparam logic [19:0] W2   = 20'd1 << 14;
  localparam logic [19:0] LD1  = 20'd1 << 13;
  localparam logic [19:0] LD2  = 20'd1 << 12;
  localparam logic [19:0] LL   = 20'd1 << 11;
  localparam logic [19:0] SD   = 20'd1 << 10;
  localparam logic [19:0] SL   = 20'd1 << 9;
  localparam logic [19:0] SV   = 20'd1 << 8;
  localparam logic [19:0] LV1  = 20'd1 << 7;
  localparam logic [19:0] LV2  = 20'd1 << 6;
  localparam logic [19:0] LDA1 = 20'd1 << 5;
  localparam logic [19:0] LDA2 = 20'd1 << 4;
  localparam logic [19:0] LT1  = 20'd1 << 3;
  localparam logic [19:0] LT2  = 20'd1 << 2;
  localparam logic [19:0] DSL  = 20'd1 << 1;
  localparam logic [19:0] PSL  = 20'd1 << 0;

  logic [19:0] obs;
  assign obs = {mem_resp, pmem_read, pmem_write, write_back, write1, write2,
                load_dbit1, load_dbit2, load_lru, set_dbit, set_lbit, set_vbit,
                load_vbit1, load_vbit2, load_data1, load_data2, load_tag1,
                load_tag2, data_sel, phys_sel};

  // Model: way index 0 = way1, 1 = way2; lru[s] names the victim way.
  bit       valid [2][8];
  bit [8:0] tagm  [2][8];
  bit       dirty [2][8];
  bit       lru   [8];
  int       hits, misses;
  int       checks, errors;

  function automatic int find(input int s, input bit [8:0] tg);
    for (int w = 0; w < 2; w++)
      if (valid[w][s] && tagm[w][s] == tg) return w;
    return -1;
  endfunction

  task automatic drive_status(input int s, input bit [8:0] tg);
    int w;
    w         = find(s, tg);
    hit       = (w >= 0);
    access1   = (w == 0);
    access2   = (w == 1);
    lru_out   = lru[s];
    dirty_out = dirty[lru[s]][s];
  endtask

  task automatic step(input logic [19:0] exp, input string tag);
    #3;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s strobes obs=%05h exp=%05h", tag, obs, exp);
    end
    checks++;
    assert (hit_count === CW'(hits)) else begin
      errors++;
      $error("FAIL %s hit_count obs=%0d exp=%0d", tag, hit_count, CW'(hits));
    end
    checks++;
    assert (miss_count === CW'(misses)) else begin
      errors++;
      $error("FAIL %s miss_count obs=%0d exp=%0d", tag, miss_count, CW'(misses));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    {hit, access1, access2, lru_out, dirty_out, pmem_resp} = 6'($urandom);
    step('0, "idle");
  endtask

  // drop_at / rst_at index the post-miss cycles (0 = first WRITEBACK/ALLOCATE cycle).
  task automatic do_req(input logic [15:0] addr, input bit wr, input int lwb,
                        input int lal, input int drop_at, input int rst_at);
    int s, w, v, k;
    bit [8:0] tg;
    bit req;
    logic [19:0] e;
    s = int'(addr[6:4]);
    tg = addr[15:7];
    req = 1'b1;
    k = 0;
    mem_write = wr;
    mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    pmem_resp = 1'($urandom_range(0, 1));
    if (find(s, tg) < 0) begin
      drive_status(s, tg);
      step('0, "miss_detect");
      misses++;
      v = int'(lru[s]);
      pmem_resp = 1'b0;
      if (dirty[v][s]) begin
        for (int i = 0; i < lwb; i++) begin
          if (k == drop_at) begin mem_read = 1'b0; mem_write = 1'b0; req = 1'b0; end
          if (k == rst_at) begin
            rst_n = 1'b0;
            step('0, "reset_in_miss");
            hits = 0; misses = 0; rst_n = 1'b1;
            idle_cycle();
            return;
          end
          drive_status(s, tg);
          pmem_resp = (i == lwb - 1);
          step(PW | WB | (v == 1 ? (DSL | PSL) : 20'd0), "writeback");
          k++;
        end
      end
      for (int i = 0; i < lal; i++) begin
        if (k == drop_at) begin mem_read = 1'b0; mem_write = 1'b0; req = 1'b0; end
        if (k == rst_at) begin
          rst_n = 1'b0;
          step('0, "reset_in_miss");
          hits = 0; misses = 0; rst_n = 1'b1;
          idle_cycle();
          return;
        end
        drive_status(s, tg);
        pmem_resp = (i == lal - 1);
        e = PR;
        if (i == lal - 1)
          e |= SV | (v == 0 ? (LDA1 | LT1 | LV1 | LD1) : (LDA2 | LT2 | LV2 | LD2));
        step(e, "allocate");
        k++;
      end
      valid[v][s] = 1'b1;
      tagm[v][s]  = tg;
      dirty[v][s] = 1'b0;
    end
    if (!req) begin
      idle_cycle();
      return;
    end
    drive_status(s, tg);
    pmem_resp = 1'($urandom_range(0, 1));
    w = find(s, tg);
    e = MR | LL | (w == 0 ? SL : 20'd0);
    if (wr) e |= SD | (w == 0 ? (W1 | LD1) : (W2 | LD2));
    step(e, wr ? "write_hit" : "read_hit");
    hits++;
    lru[s] = (w == 0);
    if (wr) dirty[w][s] = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int lw, la, dr;
    bit [8:0] rt;
    bit [2:0] rs;
    checks = 0; errors = 0; hits = 0; misses = 0;
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; pmem_resp = 1'b1;
    hit = 1'b1; access1 = 1'b1; access2 = 1'b0; lru_out = 1'b0; dirty_out = 1'b0;
    @(posedge clk);
    #1;
    step('0, "reset");
    rst_n = 1'b1;
    idle_cycle();

    do_req(16'h1234, 1'b0, 1, 3, -1, -1);
    do_req(16'h1234, 1'b1, 1, 1, -1, -1);
    do_req(16'h1234, 1'b0, 1, 1, -1, -1);
    do_req(16'h0030, 1'b0, 2, 2, -1, -1);
    do_req(16'h0230, 1'b1, 3, 2, -1, -1);
    do_req(16'h0430, 1'b0, 2, 3, -1, -1);
    do_req(16'h0630, 1'b0, 2, 3, -1, 1);
    do_req(16'h0630, 1'b0, 2, 3, -1, -1);
    do_req(16'h0830, 1'b1, 2, 4, 1, -1);
    idle_cycle();

    for (int n = 0; n < 80; n++) begin
      rs = $urandom_range(0, 1) ? 3'd3 : 3'd5;
      rt = 9'($urandom_range(0, 3));
      lw = $urandom_range(1, 4);
      la = $urandom_range(1, 4);
      dr = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
      do_req({rt, rs, 4'h0}, 1'($urandom_range(0, 1)), lw, la, dr, -1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    do_req(16'h1234, 1'b0, 1, 2, -1, -1);
    rst_n = 1'b0;
    step('0, "reset_again");
    hits = 0; misses = 0; rst_n = 1'b1;
    for (int n = 0; n < 17; n++) do_req(16'h1234, 1'b0, 1, 1, -1, -1);
    #3;
    checks++;
    assert (hit_count === 4'd1) else begin
      errors++;
      $error("FAIL hit_wrap obs=%0d exp=1", hit_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
